// File: rtl/uart_tx.sv
// 8N1 UART transmitter, rising-edge triggered by tx_start, one frame per edge.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1).
module uart_tx #(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned BAUD_RATE    = 9600,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_pin,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop
`ifdef UART_TX_PARITY_EN
    , StParity
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      data_q, data_d;
  logic            start_q;
  logic            tx_pin_q, tx_pin_d;
  logic            cnt_last;
  logic            start_cond;

  assign cnt_last   = (cnt_q == CntLast);
  assign start_cond = tx_start & ~start_q & (state_q == StIdle);

  // start_q resets high so a start level held through reset release is not an edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      start_q  <= 1'b1;
      tx_pin_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      start_q  <= tx_start;
      tx_pin_q <= tx_pin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    if (state_q == StIdle) begin
      if (start_cond) begin
        data_d  = tx_data;
        cnt_d   = '0;
        idx_d   = '0;
        state_d = StStart;
      end
    end else begin
      cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
      if (cnt_last) begin
        unique case (state_q)
          StStart: state_d = StData;
          StData: begin
            if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
`ifdef UART_TX_PARITY_EN
          StParity: state_d = StStop;
`endif
          StStop:  state_d = StIdle;
          default: state_d = StIdle;
        endcase
      end
    end
  end

  // Line level is computed from the next state so tx_pin itself is a flop output
  always_comb begin
    tx_pin_d = 1'b1;
    unique case (state_d)
      StStart:  tx_pin_d = 1'b0;
      StData:   tx_pin_d = data_q[idx_d];
`ifdef UART_TX_PARITY_EN
      StParity: tx_pin_d = ^data_q;
`endif
      default:  tx_pin_d = 1'b1;
    endcase
  end

  always_comb begin
    tx_busy = (state_q != StIdle);
    tx_done = (state_q == StStop) & cnt_last;
  end

  assign tx_pin = tx_pin_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=16; frame tables cover both the 8N1
// build and the UART_TX_PARITY_EN build.
module tb_uart_tx;

  localparam int Cpb = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBits = 11;
`else
  localparam int NBits = 10;
`endif

  localparam int ModePulse = 0;
  localparam int ModeHold  = 1;
  localparam int ModePoke  = 2;

  logic       clk;
  logic       reset;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_pin;
  logic       tx_busy;
  logic       tx_done;

  int n_vec = 0;
  int n_bad = 0;

  uart_tx #(
    .CLK_FREQ (16),
    .BAUD_RATE(1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_pin  (tx_pin),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame bit i is the i-th bit on the line: start, d0..d7, [parity], stop
  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
    int          mode;
    string       name;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise tx_start now; the next edge accepts, and every cycle of the frame is checked
  task automatic run_frame(input logic [7:0] d, input logic [10:0] frame, input int mode,
                           input string name);
    int len;
    len      = NBits * Cpb;
    tx_data  = d;
    tx_start = 1'b1;
    step();
    if (mode == ModePulse) tx_start = 1'b0;
    for (int k = 1; k <= len; k++) begin
      if (mode == ModePoke && k == 68) tx_start = 1'b0;
      if (mode == ModePoke && k == 70) begin
        tx_start = 1'b1;
        tx_data  = 8'hFF;
      end
      check({name, "/pin"}, tx_pin, frame[(k-1)/Cpb]);
      check({name, "/busy"}, tx_busy, 1'b1);
      check({name, "/done"}, tx_done, (k == len));
      step();
    end
    check({name, "/idle_pin"}, tx_pin, 1'b1);
    check({name, "/idle_busy"}, tx_busy, 1'b0);
    check({name, "/idle_done"}, tx_done, 1'b0);
  endtask

  task automatic watch_quiet(input int cycles, input string name);
    logic ok;
    ok = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      if (tx_pin !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) ok = 1'b0;
      step();
    end
    check({name, "/quiet"}, ok, 1'b1);
  endtask

  initial begin
`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'h55, 11'h4AA, ModePulse, "b55"};
    vecs[1] = '{8'hA3, 11'h546, ModePulse, "bA3"};
    vecs[2] = '{8'hA2, 11'h744, ModePulse, "bA2"};
    vecs[3] = '{8'h41, 11'h482, ModeHold,  "hold41"};
    vecs[4] = '{8'h41, 11'h482, ModePulse, "again41"};
    vecs[5] = '{8'h0F, 11'h41E, ModePoke,  "poke0F"};
    vecs[6] = '{8'hC3, 11'h586, ModePulse, "bC3"};
`else
    vecs[0] = '{8'h55, 11'h2AA, ModePulse, "b55"};
    vecs[1] = '{8'hA3, 11'h346, ModePulse, "bA3"};
    vecs[2] = '{8'hA2, 11'h344, ModePulse, "bA2"};
    vecs[3] = '{8'h41, 11'h282, ModeHold,  "hold41"};
    vecs[4] = '{8'h41, 11'h282, ModePulse, "again41"};
    vecs[5] = '{8'h0F, 11'h21E, ModePoke,  "poke0F"};
    vecs[6] = '{8'hC3, 11'h386, ModePulse, "bC3"};
`endif

    reset    = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst/pin", tx_pin, 1'b1);
    check("rst/busy", tx_busy, 1'b0);
    check("rst/done", tx_done, 1'b0);
    reset = 1'b1;
    step();
    step();

    // Pulse entries run back to back: the next rise lands in the first idle cycle
    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].data, vecs[i].frame, vecs[i].mode, vecs[i].name);
      if (vecs[i].mode == ModeHold) begin
        watch_quiet(340, {vecs[i].name, "/held"});
      end else if (vecs[i].mode == ModePoke) begin
        watch_quiet(40, {vecs[i].name, "/nosecond"});
      end
      if (vecs[i].mode != ModePulse) begin
        tx_start = 1'b0;
        step();
        step();
      end
    end

    // Reset asserted asynchronously at cycle 50 of a 0x00 frame
    tx_data  = 8'h00;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    repeat (49) step();
    check("midrst/pre_busy", tx_busy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("midrst/pin", tx_pin, 1'b1);
    check("midrst/busy", tx_busy, 1'b0);
    check("midrst/done", tx_done, 1'b0);
    repeat (3) step();
    check("midrst/hold_done", tx_done, 1'b0);
    reset = 1'b1;
    step();
`ifdef UART_TX_PARITY_EN
    run_frame(8'hC3, 11'h586, ModePulse, "postrst");
`else
    run_frame(8'hC3, 11'h386, ModePulse, "postrst");
`endif

    // tx_start high across reset release must not launch a frame
    reset    = 1'b0;
    tx_start = 1'b1;
    step();
    step();
    reset = 1'b1;
    watch_quiet(200, "rst_start_high");
    tx_start = 1'b0;
    step();
`ifdef UART_TX_PARITY_EN
    run_frame(8'h55, 11'h4AA, ModePulse, "final55");
`else
    run_frame(8'h55, 11'h2AA, ModePulse, "final55");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
